// File: rtl/issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared types and constants for the issue scheduler.
//   slot_t      : one pipeline slot {valid, rd, wr, is_load, is_mul}
//   ZERO_REG    : architectural zero register (x31); never a hazard source
//   EMPTY_SLOT  : bubble value, its tag already reads as ZERO_REG
//   ex_action_e : what the EX slot does at the next clock edge
//   slot_tag()  : forwarding tag of a slot (ZERO_REG when the slot is empty)
// ---------------------------------------------------------------------------
package sched_pkg;

    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
        logic       is_mul;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{
        valid   : 1'b0,
        rd      : ZERO_REG,
        wr      : 1'b0,
        is_load : 1'b0,
        is_mul  : 1'b0
    };

    typedef enum logic [1:0] {
        EX_BUBBLE,
        EX_LOAD,
        EX_HOLD,
        EX_KILL
    } ex_action_e;

    function automatic logic [4:0] slot_tag(input slot_t s);
        return s.valid ? s.rd : ZERO_REG;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// issue_scheduler_if
// Bundles the decode handshake and the forwarding/write-back controls that
// the issue scheduler exchanges with the rest of the integer pipeline.
//   master : decode side (drives id_* and flush, observes everything else)
//   slave  : the scheduler itself
// Signals:
//   id_valid/id_ready, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load,
//   id_is_mul, flush, ex_reg, mem_reg, ex_fwd_en, mem_fwd_en, wb_reg,
//   wb_wr_en, mul_busy
// ---------------------------------------------------------------------------
interface issue_scheduler_if;

    logic       id_valid;
    logic       id_ready;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_wr_en;
    logic       id_is_load;
    logic       id_is_mul;
    logic       flush;

    logic [4:0] ex_reg;
    logic [4:0] mem_reg;
    logic       ex_fwd_en;
    logic       mem_fwd_en;
    logic [4:0] wb_reg;
    logic       wb_wr_en;
    logic       mul_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load,
               id_is_mul, flush,
        input  id_ready, ex_reg, mem_reg, ex_fwd_en, mem_fwd_en, wb_reg,
               wb_wr_en, mul_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load,
               id_is_mul, flush,
        output id_ready, ex_reg, mem_reg, ex_fwd_en, mem_fwd_en, wb_reg,
               wb_wr_en, mul_busy
    );

endinterface

// File: rtl/issue_scheduler_hazard_check.sv
// ---------------------------------------------------------------------------
// hazard_check
// Combinational load-use detector: flags when a decode source register
// matches the destination of a load currently sitting in EX, whose data
// will only exist at the end of MEM.
// Ports:
//   ex_slot  in  slot_t  current EX slot
//   rs1, rs2 in  5       decode source registers
//   load_use out 1       decode must wait one cycle
// ---------------------------------------------------------------------------
module hazard_check
    import sched_pkg::*;
(
    input  slot_t      ex_slot,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       load_use
);

    logic ex_produces_late;
    logic mul_unused;

    // Only a valid, writing load to a real register can create the hazard;
    // the zero register is masked so reads of x31 never stall.
    assign ex_produces_late = ex_slot.valid & ex_slot.is_load & ex_slot.wr &
                              (ex_slot.rd != ZERO_REG);

    assign load_use = ex_produces_late &
                      ((rs1 == ex_slot.rd) | (rs2 == ex_slot.rd));

    assign mul_unused = ex_slot.is_mul;

endmodule

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
// Sits between decode and the EX/MEM/WB pipeline registers. Tracks the
// destination register of the instruction in each of EX, MEM and WB,
// publishes forwarding tags/enables, stalls decode on load-use hazards and,
// when ISSUE_SCHED_MUL_EN is defined, holds EX for multi-cycle multiplies.
// Without ISSUE_SCHED_MUL_EN, id_is_mul is ignored and mul_busy is 0.
// Parameters:
//   MUL_LAT  cycles a multiply occupies EX (>=1)
// Ports:
//   clk      in  pipeline clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   sif      issue_scheduler_if.slave (decode handshake, forwarding tags,
//            write-back control, mul_busy)
// ---------------------------------------------------------------------------
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int MUL_LAT = 4
)
(
    input  logic              clk,
    input  logic              reset_n,
    issue_scheduler_if.slave  sif
);

    slot_t      ex_q, mem_q, wb_q;
    slot_t      ex_d, mem_d;
    slot_t      id_slot;
    ex_action_e ex_action;
    logic       load_use;
    logic       hold;
    logic       accept;
    logic       id_mul;
    logic [4:0] unused_fields;

    hazard_check u_hazard (
        .ex_slot  (ex_q),
        .rs1      (sif.id_rs1),
        .rs2      (sif.id_rs2),
        .load_use (load_use)
    );

`ifdef ISSUE_SCHED_MUL_EN
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    assign hold   = (mul_cnt_q != '0);
    assign id_mul = sif.id_is_mul;

    // Multiply countdown: loads on entry to EX, counts the extra EX cycles
    // down while held, and is wiped by a flush or a non-multiply entry.
    always_comb begin
        mul_cnt_d = '0;
        case (ex_action)
            EX_HOLD: mul_cnt_d = mul_cnt_q - CNT_W'(1);
            EX_LOAD: mul_cnt_d = id_mul ? MUL_INIT : '0;
            default: mul_cnt_d = '0;
        endcase
    end

    // Counter register; cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_cnt_q <= '0;
        end else begin
            mul_cnt_q <= mul_cnt_d;
        end
    end
`else
    logic mul_unused;

    assign hold       = 1'b0;
    assign id_mul     = 1'b0;
    assign mul_unused = sif.id_is_mul & (MUL_LAT > 1);
`endif

    // Decode is refused during reset, on a flush, while a multiply still owns
    // EX, or when it would read a load result that is not yet available.
    assign sif.id_ready = reset_n & ~sif.flush & ~hold & ~load_use;
    assign accept       = sif.id_valid & sif.id_ready;

    // The write flag is normalised at entry so that a write to x31 never
    // shows up as a forwarding or register-file write enable downstream.
    assign id_slot = '{
        valid   : 1'b1,
        rd      : sif.id_rd,
        wr      : sif.id_wr_en & (sif.id_rd != ZERO_REG),
        is_load : sif.id_is_load,
        is_mul  : id_mul
    };

    // Decide what EX does next. Flush outranks the multiply hold, which in
    // turn outranks a normal accept (accept is already blocked by both).
    always_comb begin
        ex_action = EX_BUBBLE;
        if (sif.flush) begin
            ex_action = EX_KILL;
        end else if (hold) begin
            ex_action = EX_HOLD;
        end else if (accept) begin
            ex_action = EX_LOAD;
        end
    end

    // Next EX/MEM contents. A held multiply stays in EX and sends a bubble to
    // MEM; a flush kills the EX instruction so MEM also receives a bubble.
    always_comb begin
        ex_d  = EMPTY_SLOT;
        mem_d = ex_q;
        case (ex_action)
            EX_LOAD: ex_d = id_slot;
            EX_HOLD: begin
                ex_d  = ex_q;
                mem_d = EMPTY_SLOT;
            end
            EX_KILL: mem_d = EMPTY_SLOT;
            default: ex_d = EMPTY_SLOT;
        endcase
    end

    // Slot registers; MEM always drains into WB, and WB retires every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= EMPTY_SLOT;
            mem_q <= EMPTY_SLOT;
            wb_q  <= EMPTY_SLOT;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= mem_q;
        end
    end

    // A load's data is not ready in EX, and a multiply only has its result
    // in the last EX cycle, so EX forwarding is gated by both.
    assign sif.ex_reg     = slot_tag(ex_q);
    assign sif.ex_fwd_en  = ex_q.valid & ex_q.wr & ~ex_q.is_load & ~hold;
    assign sif.mem_reg    = slot_tag(mem_q);
    assign sif.mem_fwd_en = mem_q.valid & mem_q.wr;
    assign sif.wb_reg     = slot_tag(wb_q);
    assign sif.wb_wr_en   = wb_q.valid & wb_q.wr;
    assign sif.mul_busy   = hold;

    assign unused_fields = {ex_q.is_mul, mem_q.is_load, mem_q.is_mul,
                            wb_q.is_load, wb_q.is_mul};

endmodule

// File: tb/tb_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_issue_scheduler
// Drives directed and random decode traffic into issue_scheduler. Each
// stimulus cycle pushes the predicted outputs into a queue; a monitor on the
// falling edge pops and compares. The prediction comes from a timeline of
// in-flight instructions (cycle span in EX; MEM/WB follow one and two
// cycles later), with flush and reset removing entries.
// ---------------------------------------------------------------------------
module tb_issue_scheduler;

    localparam int MUL_LAT = 4;
`ifdef ISSUE_SCHED_MUL_EN
    localparam int EFF_LAT = MUL_LAT;
`else
    localparam int EFF_LAT = 1;
`endif

    typedef struct {
        int         ex_start;
        int         ex_end;
        logic [4:0] rd;
        bit         wr;
        bit         load;
    } flight_t;

    typedef struct {
        int         cyc;
        logic [4:0] ex_reg;
        logic [4:0] mem_reg;
        logic [4:0] wb_reg;
        bit         ex_fwd;
        bit         mem_fwd;
        bit         wb_wr;
        bit         busy;
        bit         ready;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    issue_scheduler_if bus();

    issue_scheduler #(.MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (bus)
    );

    always #5 clk = ~clk;

    flight_t inflight[$];
    obs_t    expq[$];
    int      cyc = 0;
    int      vectors = 0;
    int      miscompares = 0;

    // Index of the instruction occupying EX during cycle t, or -1.
    function automatic int find_ex(int t);
        foreach (inflight[i])
            if (inflight[i].ex_start <= t && t <= inflight[i].ex_end) return i;
        return -1;
    endfunction

    // Index of the instruction that left EX k cycles before cycle t, or -1.
    function automatic int find_after(int t, int k);
        foreach (inflight[i])
            if (inflight[i].ex_end + k == t) return i;
        return -1;
    endfunction

    // Expected outputs for cycle t given the decode sources and flush.
    function automatic obs_t predict(int t, logic [4:0] rs1, logic [4:0] rs2, bit fl);
        obs_t    o;
        flight_t f;
        int      e, m, w;
        e = find_ex(t);
        m = find_after(t, 1);
        w = find_after(t, 2);
        o.cyc = t;
        o.ex_reg = 5'd31; o.ex_fwd = 0; o.busy = 0; o.ready = !fl;
        o.mem_reg = 5'd31; o.mem_fwd = 0;
        o.wb_reg = 5'd31; o.wb_wr = 0;
        if (e >= 0) begin
            f = inflight[e];
            o.ex_reg = f.rd;
            o.busy   = (t < f.ex_end);
            o.ex_fwd = f.wr && f.rd != 5'd31 && !f.load && t == f.ex_end;
            if (o.busy) o.ready = 0;
            if (f.load && f.wr && f.rd != 5'd31 && (rs1 == f.rd || rs2 == f.rd))
                o.ready = 0;
        end
        if (m >= 0) begin
            o.mem_reg = inflight[m].rd;
            o.mem_fwd = inflight[m].wr && inflight[m].rd != 5'd31;
        end
        if (w >= 0) begin
            o.wb_reg = inflight[w].rd;
            o.wb_wr  = inflight[w].wr && inflight[w].rd != 5'd31;
        end
        return o;
    endfunction

    // One decode cycle: drive inputs, record the prediction, advance model.
    task automatic applyStimulus(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input bit wr, input bit ld,
                                 input bit mul, input bit fl, output bit acc);
        obs_t    o;
        flight_t nf;
        int      e, lat;
        @(posedge clk);
        #1;
        reset_n        = 1'b1;
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_rd      = rd;
        bus.id_wr_en   = wr;
        bus.id_is_load = ld;
        bus.id_is_mul  = mul;
        bus.flush      = fl;
        o = predict(cyc, rs1, rs2, fl);
        expq.push_back(o);
        if (fl) begin
            e = find_ex(cyc);
            if (e >= 0) inflight.delete(e);
        end
        acc = v && o.ready;
        if (acc) begin
            lat = (mul && !ld) ? EFF_LAT : 1;
            nf.ex_start = cyc + 1;
            nf.ex_end   = cyc + lat;
            nf.rd       = rd;
            nf.wr       = wr;
            nf.load     = ld;
            inflight.push_back(nf);
        end
        while (inflight.size() > 0 && inflight[0].ex_end + 2 < cyc + 1)
            void'(inflight.pop_front());
        cyc++;
    endtask

    // One cycle with reset asserted between edges: everything clears at once.
    task automatic applyReset();
        obs_t o;
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        inflight.delete();
        o = predict(cyc, 5'd0, 5'd0, 1'b0);
        o.ready = 0;
        expq.push_back(o);
        cyc++;
    endtask

    task automatic checkOutput(input string name, input int c, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp_v);
        end
    endtask

    // Present one instruction until the model says it was taken (bounded).
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input bit wr, input bit ld, input bit mul);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, rs1, rs2, rd, wr, ld, mul, 1'b0, acc);
            tries++;
        end
        checkOutput("issue_bound", cyc, int'(acc), 1);
    endtask

    task automatic idle(input bit fl);
        bit acc;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, fl, acc);
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 5);
        if (r == 5) return 5'($urandom_range(0, 31));
        if (r == 4) return 5'd31;
        return 5'(r + 1);
    endfunction

    // Monitor: compares every DUT output against the oldest prediction.
    always @(negedge clk) begin
        obs_t o;
        if (expq.size() > 0) begin
            o = expq.pop_front();
            checkOutput("id_ready",   o.cyc, int'(bus.id_ready),   int'(o.ready));
            checkOutput("ex_reg",     o.cyc, int'(bus.ex_reg),     int'(o.ex_reg));
            checkOutput("ex_fwd_en",  o.cyc, int'(bus.ex_fwd_en),  int'(o.ex_fwd));
            checkOutput("mem_reg",    o.cyc, int'(bus.mem_reg),    int'(o.mem_reg));
            checkOutput("mem_fwd_en", o.cyc, int'(bus.mem_fwd_en), int'(o.mem_fwd));
            checkOutput("wb_reg",     o.cyc, int'(bus.wb_reg),     int'(o.wb_reg));
            checkOutput("wb_wr_en",   o.cyc, int'(bus.wb_wr_en),   int'(o.wb_wr));
            checkOutput("mul_busy",   o.cyc, int'(bus.mul_busy),   int'(o.busy));
        end
    end

    initial begin
        bit         acc, pending, v, fl;
        logic [4:0] rs1, rs2, rd;
        bit         wr, ld, mul;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_wr_en = 0; bus.id_is_load = 0; bus.id_is_mul = 0; bus.flush = 0;
        pending = 0; rs1 = 0; rs2 = 0; rd = 0; wr = 0; ld = 0; mul = 0;

        repeat (3) applyReset();

        // ADD x1 then SUB reading x1 back-to-back
        issue(5'd4, 5'd5, 5'd1, 1, 0, 0);
        issue(5'd1, 5'd6, 5'd7, 1, 0, 0);
        idle(0);
        // LDUR x2 then ADD reading x2
        issue(5'd8, 5'd0, 5'd2, 1, 1, 0);
        issue(5'd9, 5'd2, 5'd10, 1, 0, 0);
        idle(0);
        // LDUR x31 then reader of x31
        issue(5'd8, 5'd0, 5'd31, 1, 1, 0);
        issue(5'd31, 5'd31, 5'd11, 1, 0, 0);
        idle(0);
        // MUL x3 then dependent
        issue(5'd4, 5'd5, 5'd3, 1, 0, 1);
        issue(5'd3, 5'd0, 5'd12, 1, 0, 0);
        repeat (3) idle(0);
        // ADD x6, MUL x4, flush while the multiply is held
        issue(5'd1, 5'd2, 5'd6, 1, 0, 0);
        issue(5'd1, 5'd2, 5'd4, 1, 0, 1);
        idle(1);
        repeat (3) idle(0);
        // reset in the middle of traffic
        issue(5'd1, 5'd2, 5'd13, 1, 0, 0);
        issue(5'd1, 5'd2, 5'd14, 1, 1, 0);
        applyReset();
        issue(5'd14, 5'd2, 5'd15, 1, 0, 0);
        repeat (3) idle(0);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset();
            end else begin
                if (!pending) begin
                    rs1 = pick_reg(); rs2 = pick_reg(); rd = pick_reg();
                    wr  = ($urandom_range(0, 9) < 9);
                    ld  = ($urandom_range(0, 3) == 0);
                    mul = !ld && ($urandom_range(0, 4) == 0);
                    pending = 1;
                end
                v  = ($urandom_range(0, 9) < 8);
                fl = ($urandom_range(0, 19) == 0);
                applyStimulus(v, rs1, rs2, rd, wr, ld, mul, fl, acc);
                if (acc) pending = 0;
            end
        end

        @(negedge clk);
        #1;
        checkOutput("drained", cyc, expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

- Sequences the integer pipeline around the operand forwarding muxes.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB.
- Drives the ALU-stage and MEM-stage forward enables/register tags consumed by the forwarding unit.
- Stalls decode on load-use hazards and holds EX for multi-cycle multiplies; sits between decode and the EX/MEM/WB pipeline registers.

## Interface
Parameters:
- MUL_LAT, 4: cycles a multiply occupies EX (≥1; 1 = single-cycle).

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  scheduler accepts it this cycle (combinational; forced 0 while reset_n low)
- id_rs1, id_rs2  in  5  source registers of decode instruction
- id_rd  in  5  destination register
- id_wr_en  in  1  instruction writes id_rd
- id_is_load  in  1  result produced in MEM
- id_is_mul  in  1  multi-cycle multiply
- flush  in  1  kill decode and EX contents (mispredict)
- ex_reg, mem_reg  out  5  forwarding tags for EX/MEM stage (31 when slot empty)
- ex_fwd_en, mem_fwd_en  out  1  stage result valid for forwarding
- wb_reg  out  5, wb_wr_en  out  1  register-file write control
- mul_busy  out  1  EX held by multiply

## Operation
- Three slots EX, MEM, WB, each {valid, rd, wr, is_load, is_mul}; reset clears all, tags read 5'd31, enables 0, mul_busy 0.
- Transfer when id_valid & id_ready: instruction enters EX next cycle; otherwise EX receives a bubble unless held.
- Normal advance each cycle: EX→MEM→WB; WB slot retires.
- Register 31 is the zero register: never creates a hazard, never forwarded (enables 0 when rd==31 or !wr).
- ex_fwd_en = EX.valid & EX.wr & !EX.is_load & mul_cnt==0.
- mem_fwd_en = MEM.valid & MEM.wr (loads included).
- Load-use: EX.valid & EX.is_load & EX.wr & EX.rd!=31 & (id_rs1==EX.rd | id_rs2==EX.rd) → id_ready=0; bubble into EX.
- Multiply: on entry to EX, mul_cnt loads MUL_LAT-1. While mul_cnt≠0: EX holds, MEM receives bubble, mul_busy=1, id_ready=0, mul_cnt decrements. At mul_cnt==0 the multiply advances normally.
- flush: EX slot and mul_cnt cleared next cycle; decode instruction not accepted (id_ready=0); MEM/WB unaffected and advance normally. Flush wins over hold and load-use.
- Reset asserted mid-operation: all slots and counter cleared immediately.

## Timing
- Accept-to-EX latency 1 cycle; EX→MEM 1; MEM→WB 1.
- Load-use stall exactly 1 cycle: t load in EX, dependent stalled; t+1 load in MEM (mem_fwd_en=1), dependent accepted.
- Multiply: EX occupancy MUL_LAT cycles; id_ready low MUL_LAT-1 cycles; ex_fwd_en high only in final EX cycle.
- Load-use and multiply hold in same cycle: hold dominates; load-use re-evaluated after release.

## Configuration
- ISSUE_SCHED_MUL_EN defined: multi-cycle multiply support as above.
- Undefined: id_is_mul ignored, multiplies treated as single-cycle ALU ops, mul_cnt absent, mul_busy tied 0.

## Structure
- Package sched_pkg: slot_t struct, ZERO_REG = 5'd31, empty-slot constant.
- One sub-module hazard_check: combinational load-use compare of rs1/rs2 against EX slot, zero-register masked.

## Test plan
- Reset pulse mid-stream → ex_reg=mem_reg=wb_reg=31, all enables 0, mul_busy 0; id_ready=1 after release.
- ADD x1 then SUB rs1=x1 back-to-back → SUB cycle shows ex_reg=1, ex_fwd_en=1, id_ready=1, no stall.
- LDUR x2 then ADD rs2=x2 → id_ready=0 for one cycle, ex_fwd_en=0; next cycle mem_reg=2, mem_fwd_en=1, ADD accepted.
- LDUR x31 then reader of x31 → no stall, ex_fwd_en=0, mem_fwd_en=0.
- MUL x3 (MUL_LAT=4) then dependent on x3 → mul_busy 3 cycles, id_ready low 3 cycles, MEM bubbles; 4th cycle ex_reg=3, ex_fwd_en=1.
- flush during multiply busy → next cycle mul_busy=0, ex_reg=31; prior MEM instruction reaches WB with wb_wr_en=1.
